// File: rtl/flag111_pkg.sv
// Shared definitions for the "111" flag transmitter: state encoding, flag pattern and defaults.
package flag111_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned FlagLen      = 4;
  localparam logic [FlagLen-1:0] FlagPat = 4'b0111;

  typedef enum logic [2:0] {
    StIdle,
    StFlag,
    StData,
    StStuff,
    StEnd
  } state_e;

endpackage

// File: rtl/flag111_tx.sv
// Transmit end of the "111" flag protocol: flag 0111, MSB-first payload with a zero
// stuffed after every two consecutive data ones (except after the last bit), then an END cycle.
module flag111_tx
  import flag111_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              ready_o,
  output logic              z_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CntW = $clog2(DATA_W > FlagLen ? DATA_W : FlagLen);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        ones_q, ones_d;
  logic              z_q, z_d;
  logic [1:0]        flag_idx;
  logic              emit;

  // z is registered, so every branch computes the line value for the cycle being entered.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    z_d      = 1'b0;
    emit     = 1'b0;
    flag_idx = 2'(FlagLen - 2) - cnt_q[1:0];

    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          state_d = StFlag;
          sh_d    = din_i;
          cnt_d   = '0;
          ones_d  = '0;
          z_d     = FlagPat[FlagLen-1];
        end
      end
      StFlag: begin
        if (cnt_q == CntW'(FlagLen - 1)) begin
          state_d = StData;
          cnt_d   = '0;
          emit    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          z_d   = FlagPat[flag_idx];
        end
      end
      StData: begin
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = StEnd;
        end else if (ones_q == 2'd2) begin
          state_d = StStuff;
          ones_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          emit  = 1'b1;
        end
      end
      StStuff: begin
        state_d = StData;
        cnt_d   = cnt_q + 1'b1;
        emit    = 1'b1;
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shift out the next payload bit and track the run of data ones it extends.
    if (emit) begin
      z_d    = sh_q[DATA_W-1];
      sh_d   = sh_q << 1;
      ones_d = sh_q[DATA_W-1] ? ones_q + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      z_q     <= z_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StEnd);
  assign z_o     = z_q;

endmodule

// File: tb/tb_flag111_tx.sv
// Randomized bench for flag111_tx: each frame on z is compared against a queue-based frame model.
module tb_flag111_tx;

  localparam int unsigned W = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         load_i;
  logic [W-1:0] din_i;
  logic         ready_o;
  logic         z_o;
  logic         busy_o;
  logic         done_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          exp_q[$];
  bit          obs_q[$];

  always #5 clk_i = ~clk_i;

  flag111_tx #(
    .DATA_W(W)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load_i),
    .din_i  (din_i),
    .ready_o(ready_o),
    .z_o    (z_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected busy-cycle line values: flag, payload MSB first with stuffing, END zero.
  function automatic void model(input logic [W-1:0] d);
    int run = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    repeat (3) exp_q.push_back(1'b1);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      run = d[i] ? run + 1 : 0;
      if (run == 2 && i > 0) begin
        exp_q.push_back(1'b0);
        run = 0;
      end
    end
    exp_q.push_back(1'b0);
  endfunction

  task automatic compare_frame(input string tag, input logic [W-1:0] d);
    logic [31:0] ov = '0;
    logic [31:0] ev = '0;
    int run = 0;
    int fires = 0;
    model(d);
    check({tag, "/len"}, obs_q.size(), exp_q.size());
    foreach (obs_q[i]) ov = {ov[30:0], obs_q[i]};
    foreach (exp_q[i]) ev = {ev[30:0], exp_q[i]};
    check({tag, "/z"}, ov, ev);
    foreach (obs_q[i]) begin
      run = obs_q[i] ? run + 1 : 0;
      if (run == 3) fires++;
    end
    check({tag, "/flag111"}, fires, 1);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after the frame.
  task automatic send_frame(input string tag, input logic [W-1:0] d, input bit noise,
                            input int fixed_len);
    int cyc = 0;
    int dones = 0;
    int done_at = 0;
    int rdy_bad = 0;
    check({tag, "/ready"}, ready_o, 1);
    load_i = 1'b1;
    din_i  = d;
    @(posedge clk_i);
    #1 load_i = 1'b0;
    obs_q.delete();
    @(negedge clk_i);
    while (busy_o && cyc < 40) begin
      cyc++;
      obs_q.push_back(z_o);
      if (done_o) begin
        dones++;
        done_at = cyc;
      end
      if (ready_o) rdy_bad++;
      if (noise) begin
        load_i = done_o ? 1'b0 : 1'($urandom);
        din_i  = W'($urandom);
      end
      @(negedge clk_i);
    end
    load_i = 1'b0;
    compare_frame(tag, d);
    check({tag, "/done_cnt"}, dones, 1);
    check({tag, "/done_at"}, done_at, cyc);
    check({tag, "/ready_busy"}, rdy_bad, 0);
    check({tag, "/idle_z"}, z_o, 0);
    check({tag, "/idle_ready"}, ready_o, 1);
    if (fixed_len != 0) check({tag, "/busy_cycles"}, cyc, fixed_len);
  endtask

  initial begin
    int dones;
    int busies;
    int frames;
    int idle_run;
    bit in_frame;
    logic [W-1:0] pending;
    logic [W-1:0] cur_din;

    rst_ni = 1'b0;
    load_i = 1'b0;
    din_i  = '0;
    #2;
    check("reset/ready", ready_o, 1);
    check("reset/busy", busy_o, 0);
    check("reset/done", done_o, 0);
    check("reset/z", z_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    send_frame("h00", 8'h00, 1'b0, 13);
    send_frame("hFF", 8'hFF, 1'b0, 16);
    send_frame("hB6", 8'hB6, 1'b1, 15);
    for (int i = 0; i < 6; i++) send_frame("rnd", W'($urandom), 1'b1, 0);

    // Abort an 0xFF frame on a data-one cycle with an asynchronous reset.
    load_i = 1'b1;
    din_i  = 8'hFF;
    @(posedge clk_i);
    #1 load_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("abort/pre_busy", busy_o, 1);
    check("abort/pre_z", z_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("abort/z", z_o, 0);
    check("abort/busy", busy_o, 0);
    check("abort/done", done_o, 0);
    check("abort/ready", ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    dones  = 0;
    busies = 0;
    repeat (3) begin
      @(negedge clk_i);
      dones  += int'(done_o);
      busies += int'(busy_o);
    end
    check("abort/no_done", dones, 0);
    check("abort/idle_after", busies, 0);
    send_frame("post_rst", 8'hFF, 1'b0, 16);

    // load held high: frames back to back with one IDLE cycle, din sampled at acceptance.
    load_i   = 1'b1;
    din_i    = W'($urandom);
    pending  = din_i;
    cur_din  = '0;
    frames   = 0;
    idle_run = 1;
    in_frame = 1'b0;
    for (int c = 0; c < 200 && frames < 4; c++) begin
      @(negedge clk_i);
      if (busy_o) begin
        if (!in_frame) begin
          check("held/idle_gap", idle_run, 1);
          in_frame = 1'b1;
          cur_din  = pending;
          obs_q.delete();
        end
        obs_q.push_back(z_o);
        din_i = W'($urandom);
      end else begin
        if (in_frame) begin
          compare_frame("held", cur_din);
          frames++;
          in_frame = 1'b0;
          idle_run = 0;
        end
        idle_run++;
        din_i   = (frames % 2 == 0) ? W'($urandom) : ~cur_din;
        pending = din_i;
      end
    end
    load_i = 1'b0;
    check("held/frames", frames, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
